// File: rtl/inst_mem_port.sv
// inst_mem_port: instruction-fetch responder. Assembles a little-endian
// 32-bit word from four byte reads of a synchronous RAM, framed by busy.
// Optional direct-mapped instruction cache compiled in with ICACHE_EN.
module inst_mem_port #(
  parameter int ADDR_W       = 17,
  parameter int ICACHE_IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ram_inst_re,
  input  logic [31:0]       ram_inst_raddr,
  output logic [31:0]       ram_inst,
  output logic              ram_inst_busy,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

`ifdef ICACHE_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HIT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   aw_q;        // latched word address (byte address >> 2)
  logic [1:0]          i_q;         // issue counter / byte lane being issued
  logic                done_q;      // all four lanes issued
  logic                cap_q;       // capture pending this cycle
  logic [1:0]          cap_lane_q;  // lane the pending capture belongs to
  logic [23:0]         asm_q;       // lanes 0..2; lane 3 is taken straight from mem_din
  logic [31:0]         ram_inst_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   mem_a_q;     // last address driven, held while idle

  logic [ADDR_W-3:0]   req_w;
  logic [31:0]         fill_word;
  logic                accept, issue, complete;
  logic                unused_raddr;

  assign req_w         = ram_inst_raddr[ADDR_W-1:2];
  assign fill_word     = {mem_din, asm_q};
  assign unused_raddr  = ^{ram_inst_raddr[31:ADDR_W], ram_inst_raddr[1:0]};
  assign ram_inst      = ram_inst_q;
  assign ram_inst_busy = busy_q;
  assign mem_wr        = 1'b0;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = ADDR_W - 2 - ICACHE_IDX_W;

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];
  logic [ICACHE_IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    cache_hit;
  logic [31:0]             hit_word;

  assign req_idx   = req_w[ICACHE_IDX_W-1:0];
  assign req_tag   = req_w[ADDR_W-3:ICACHE_IDX_W];
  assign fill_idx  = aw_q[ICACHE_IDX_W-1:0];
  assign fill_tag  = aw_q[ADDR_W-3:ICACHE_IDX_W];
  assign cache_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // In HIT the latched address still selects the line that hit.
  assign hit_word  = data_q[fill_idx];

  // Valid bits: cleared only by reset, set when a miss completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy && complete) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage: filled at miss completion, never needs reset.
  always_ff @(posedge clk) begin
    if (rdy && complete) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_word;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next state, address mux and per-cycle control strobes.
  // The first issue overlaps the accepting edge, so in IDLE the request
  // address goes straight to the RAM bus.
  always_comb begin
    state_d  = state_q;
    mem_a    = mem_a_q;
    accept   = 1'b0;
    issue    = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ram_inst_re) begin
          accept = 1'b1;
`ifdef ICACHE_EN
          if (cache_hit) state_d = S_HIT;
          else
`endif
          begin
            state_d = S_FETCH;
            mem_a   = {req_w, 2'b00};
            issue   = mem_gnt;
          end
        end
      end
      S_FETCH: begin
        if (!done_q) begin
          mem_a = {aw_q, i_q};
          issue = mem_gnt;
        end
        if (cap_q && cap_lane_q == 2'd3) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
`ifdef ICACHE_EN
      S_HIT: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request latch, issue counter, byte capture and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_q       <= '0;
      i_q        <= '0;
      done_q     <= 1'b0;
      cap_q      <= 1'b0;
      cap_lane_q <= '0;
      asm_q      <= '0;
      ram_inst_q <= '0;
      busy_q     <= 1'b0;
      mem_a_q    <= '0;
    end else if (rdy) begin
      mem_a_q    <= mem_a;
      cap_q      <= issue;
      cap_lane_q <= i_q;
      if (accept) begin
        aw_q   <= req_w;
        busy_q <= 1'b1;
      end
      if (issue) begin
        if (i_q == 2'd3) done_q <= 1'b1;
        else             i_q    <= i_q + 2'd1;
      end
      if (cap_q) begin
        case (cap_lane_q)
          2'd0:    asm_q[7:0]   <= mem_din;
          2'd1:    asm_q[15:8]  <= mem_din;
          2'd2:    asm_q[23:16] <= mem_din;
          default: ;
        endcase
      end
      if (complete) begin
        ram_inst_q <= fill_word;
        busy_q     <= 1'b0;
        i_q        <= '0;
        done_q     <= 1'b0;
      end
`ifdef ICACHE_EN
      if (state_q == S_HIT) begin
        ram_inst_q <= hit_word;
        busy_q     <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_inst_mem_port.sv
// Bench for inst_mem_port: directed cases plus randomized fetches against a
// transaction-level model (byte RAM array, optional cache tag model).
module tb_inst_mem_port;
  localparam int LIMIT = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        ram_inst_re = 1'b0;
  logic [31:0] ram_inst_raddr = '0;
  logic [31:0] ram_inst;
  logic        ram_inst_busy;
  logic        mem_gnt = 1'b1;
  logic [16:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din = '0;

  logic [7:0]  ram [0:131071];
  logic [31:0] last_word;
  bit   [63:0] c_valid;
  logic [8:0]  c_tag [64];
  int          n_cmp = 0;
  int          n_bad = 0;

  inst_mem_port dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ram_inst_re(ram_inst_re), .ram_inst_raddr(ram_inst_raddr),
    .ram_inst(ram_inst), .ram_inst_busy(ram_inst_busy),
    .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM, frozen by rdy like the DUT.
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ram_inst_re = 1'b0;
    #1;
    chk("rst_busy", 32'(ram_inst_busy), 32'd0);
    chk("rst_inst", ram_inst, 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_word = '0;
    c_valid = '0;
  endtask

  // One fetch. Grant/ready are random by percentage, with optional forced
  // low windows in cycle numbers relative to the accepting edge (k=0).
  task automatic do_fetch(input logic [31:0] raddr, input int gnt_pct, input int rdy_pct,
                          input int g0_from, input int g0_len,
                          input int r0_from, input int r0_len, input int exp_busy);
    logic [16:0] a;
    logic [16:0] prev_a;
    logic [31:0] w;
    bit          hit;
    bit          done;
    int          granted;
    int          obs_len;
    a = raddr[16:0] & 17'h1fffc;
    w = {ram[a + 17'd3], ram[a + 17'd2], ram[a + 17'd1], ram[a]};
    hit = 1'b0;
`ifdef ICACHE_EN
    hit = c_valid[a[7:2]] && (c_tag[a[7:2]] == a[16:8]);
`endif
    @(negedge clk);
    prev_a = mem_a;
    ram_inst_re = 1'b1;
    ram_inst_raddr = raddr;
    rdy = 1'b1;
    mem_gnt = (g0_len > 0 && g0_from == 0) ? 1'b0 : ($urandom_range(99) < gnt_pct);
    #1;
    if (hit) chk("hit_no_issue", 32'(mem_a), 32'(prev_a));
    else     chk("issue_addr", 32'(mem_a), 32'(a));
    granted = 0;
    @(posedge clk);
    if (!hit && mem_gnt) granted = 1;
    #1;
    chk("busy_rise", 32'(ram_inst_busy), 32'd1);
    done = 1'b0;
    obs_len = 0;
    for (int k = 1; k <= LIMIT && !done; k++) begin
      @(negedge clk);
      ram_inst_re = ($urandom_range(3) == 0);
      ram_inst_raddr = $urandom;
      mem_gnt = (k >= g0_from && k < g0_from + g0_len) ? 1'b0 : ($urandom_range(99) < gnt_pct);
      rdy = (k >= r0_from && k < r0_from + r0_len) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      #1;
      if (hit)              chk("hit_no_issue", 32'(mem_a), 32'(prev_a));
      else if (granted < 4) chk("issue_addr", 32'(mem_a), 32'(a) + 32'(granted));
      @(posedge clk);
      if (rdy) begin
        if (hit || granted == 4) done = 1'b1;
        else if (mem_gnt)        granted++;
      end
      #1;
      if (!ram_inst_busy && obs_len == 0) obs_len = k;
      if (done) begin
        chk("busy_fall", 32'(ram_inst_busy), 32'd0);
        chk("word", ram_inst, w);
        chk("busy_len", 32'(obs_len), 32'(k));
        if (exp_busy >= 0) chk("busy_len_directed", 32'(obs_len), 32'(exp_busy));
      end else begin
        chk("busy_hold", 32'(ram_inst_busy), 32'd1);
        chk("inst_hold", ram_inst, last_word);
      end
    end
    if (!done) chk("fetch_timeout", 32'd0, 32'd1);
    ram_inst_re = 1'b0;
    rdy = 1'b1;
    last_word = w;
`ifdef ICACHE_EN
    if (!hit) begin
      c_valid[a[7:2]] = 1'b1;
      c_tag[a[7:2]] = a[16:8];
    end
`endif
  endtask

  initial begin
    logic [31:0] pool [6];
    logic [31:0] ad;
    for (int j = 0; j < 131072; j++) ram[j] = 8'($urandom);
    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h00; ram[17'h103] = 8'h00;
    pool[0] = 32'h200; pool[1] = 32'h300; pool[2] = 32'h1F004;
    pool[3] = 32'h40;  pool[4] = 32'h12345; pool[5] = 32'hFFFF0123;
    last_word = '0;
    c_valid = '0;

    do_reset();
    // Basic miss, then the fixed word value from the preloaded bytes.
    do_fetch(32'h100, 100, 100, 0, 0, 0, 0, 4);
    chk("basic_word", ram_inst, 32'h00000513);
    // Misaligned request with high bits beyond ADDR_W.
    do_fetch(32'h00020106, 100, 100, 0, 0, 0, 0, 4);
    // Grant dropped for two cycles after the second issue.
    do_fetch(32'h104, 100, 100, 2, 2, 0, 0, 6);
    // rdy held low for three cycles mid-fetch.
    do_fetch(32'h108, 100, 100, 0, 0, 2, 3, 7);

    // Reset in the middle of a fetch, then a normal fetch.
    @(negedge clk);
    ram_inst_re = 1'b1; ram_inst_raddr = 32'h10C; mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ram_inst_re = 1'b0;
    @(posedge clk);
    do_reset();
    do_fetch(32'h10C, 100, 100, 0, 0, 0, 0, 4);

`ifdef ICACHE_EN
    do_fetch(32'h200, 100, 100, 0, 0, 0, 0, 4);
    do_fetch(32'h200, 100, 100, 0, 0, 0, 0, 1);
    do_reset();
    do_fetch(32'h200, 100, 100, 0, 0, 0, 0, 4);
    do_fetch(32'h300, 100, 100, 0, 0, 0, 0, 4);
    do_fetch(32'h200, 100, 100, 0, 0, 0, 0, 4);
`endif

    // Randomized fetches with random grant stalls and freezes.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(3) == 0) ad = $urandom;
      else                        ad = pool[$urandom_range(5)];
      do_fetch(ad, 70, 85, 0, 0, 0, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_mem_port.md
# inst_mem_port

Responder end of the instruction-fetch interface: accepts one-cycle fetch pulses (`ram_inst_re`, `ram_inst_raddr`) from the fetch stage, reads four bytes from the byte-wide synchronous RAM and returns a little-endian 32-bit word on `ram_inst`, framed by `ram_inst_busy`. It sits between the IF stage and the memory arbiter. An optional direct-mapped instruction cache short-circuits repeat fetches.

## Interface
- `ADDR_W`, 17: RAM byte-address width; the request address is truncated to its low `ADDR_W` bits.
- `ICACHE_IDX_W`, 6: cache index bits, giving 2^6 = 64 one-word lines. Used only with `ICACHE_EN`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `rdy`  in  1  global ready; when low, all state is frozen.
- `ram_inst_re`  in  1  fetch request pulse from IF.
- `ram_inst_raddr`  in  32  fetch byte address; bits [1:0] are ignored (the word is aligned down).
- `ram_inst`  out  32  fetched instruction word.
- `ram_inst_busy`  out  1  high while a fetch is outstanding.
- `mem_gnt`  in  1  arbiter grants the RAM address bus this cycle.
- `mem_a`  out  ADDR_W  RAM byte address.
- `mem_wr`  out  1  RAM write enable; tied to 0.
- `mem_din`  in  8  RAM read data; valid one cycle after its address.

## Operation
- **States.** IDLE, FETCH, and HIT (HIT exists only with `ICACHE_EN`).
- **IDLE.** On a rising edge with `rdy=1` and `ram_inst_re=1`:
  - latch the aligned address A = {raddr[ADDR_W-1:2], 2'b00};
  - set `ram_inst_busy`;
  - go to FETCH, or to HIT when the cache hits.
- **FETCH, issue.** A 2-bit issue counter i drives `mem_a = A + i`.
  - i advances only in cycles where `mem_gnt=1`.
  - Each granted issue sets a one-cycle capture flag tagged with i.
- **FETCH, capture.** In the cycle after a granted issue, `mem_din` is written to byte lane i of the assembly register.
  - Capture happens regardless of the `mem_gnt` value in the capture cycle.
  - Lane 0 maps to bits [7:0], lane 3 to bits [31:24].
- **Completion.** On the edge that captures lane 3:
  - `ram_inst` ← assembled word;
  - `ram_inst_busy` ← 0;
  - return to IDLE.
- **Output hold.** `ram_inst` holds its value until the next completion.
- **During a fetch.** `ram_inst_re` is ignored while busy; there is no queueing.
- **Idle bus.** `mem_a` holds its last value in IDLE.
- **`rdy=0`.** All registers hold, including the capture flag. The RAM is frozen by the same `rdy`.
- **Reset** (asynchronous, any time, including mid-fetch):
  - `ram_inst`=0, `ram_inst_busy`=0, `mem_a`=0, `mem_wr`=0;
  - state IDLE, counters 0;
  - all cache valid bits cleared.

## Timing
- **Miss latency.** Request accepted at edge E0. With the grant held high, the issue cycles are E0–E3 and the captures land at E1–E4. `ram_inst_busy` is high from E0 to E4, which is 4 cycles, and `ram_inst` is valid after E4.
- **Grant stalls.** Each cycle with `mem_gnt=0` during issue adds exactly one cycle of latency.
- **Hit latency.** Busy rises at E0; `ram_inst` is updated and busy falls at E1. Busy is therefore high for exactly 1 cycle, so every fetch produces a visible busy pulse.
- **Back-to-back.** A new request may be accepted on the edge immediately after busy falls.

## Configuration
- **Macro:** `ICACHE_EN`.
- **Defined:** a direct-mapped cache is compiled in.
  - Index = A[ICACHE_IDX_W+1:2]; tag = A[ADDR_W-1:ICACHE_IDX_W+2]; one valid bit per line.
  - Lookup happens at request acceptance.
  - A hit goes to HIT and returns the stored word without driving any issue to the RAM.
  - A miss runs FETCH and writes word, tag and valid into the line at completion.
  - There is no invalidation except reset; the instruction memory is treated as read-only.
- **Undefined:** there is no cache storage or HIT state, and every request takes the FETCH path.

## Test plan
- **Basic miss.** RAM bytes 0x100..0x103 = 13 05 00 00, `mem_gnt`=1, request 0x100 → `mem_a` = 0x100, 0x101, 0x102, 0x103 on consecutive cycles; busy high 4 cycles; `ram_inst`=0x00000513.
- **Misalignment and truncation.** Request raddr=0x00020106 with `ADDR_W`=17 → `mem_a` starts at 0x00104; the word is assembled from 0x104..0x107.
- **Grant stall.** Drop `mem_gnt` for 2 cycles after the second issue → busy high 6 cycles; the word is unchanged and correct.
- **Freeze and reset.** Hold `rdy`=0 for 3 cycles mid-fetch → busy high 7 cycles with the correct word. Separately, assert `rst` mid-fetch → busy=0, `ram_inst`=0 immediately; the next request completes normally.
- **Cache hit** (`ICACHE_EN`). Fetch 0x200 twice → the first takes 4 busy cycles; the second takes 1 busy cycle with no `mem_a` change and the same word.
- **Cache conflict** (`ICACHE_EN`). Fetch 0x200, then 0x300 (same index at IDX_W=6), then 0x200 → all three are misses, each returning the correct word.
